// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder (one full-adder cell plus a carry flop), LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub_i port for a - b.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_sr, b_sr, res, b_ld;
    logic [CW-1:0] cnt;
    logic carry, c_msb, c_ld, fa_s, fa_c, accept;
    fulladder u_fa (
        .a_i   (a_sr[0]),
        .b_i   (b_sr[0]),
        .cin_i (carry),
        .s_o   (fa_s),
        .cout_o(fa_c)
    );
    assign accept = start_i && state != SHIFT;
`ifdef SERIAL_ADDER_SUB_EN
    assign b_ld = sub_i ? ~b_i : b_i;
    assign c_ld = sub_i | cin_i;
`else
    assign b_ld = b_i;
    assign c_ld = cin_i;
`endif
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            c_msb  <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            s_o    <= '0;
            cout_o <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                state  <= SHIFT;
                busy_o <= 1'b1;
                a_sr   <= a_i;
                b_sr   <= b_ld;
                carry  <= c_ld;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                carry <= fa_c;
                res   <= {fa_s, res[WIDTH-1:1]};
                cnt   <= cnt + 1'b1;
                // carry into the MSB is the carry out of bit WIDTH-2
                if (cnt == CW'(WIDTH-2))
                    c_msb <= fa_c;
                if (cnt == CW'(WIDTH-1)) begin
                    state  <= DONE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    s_o    <= {fa_s, res[WIDTH-1:1]};
                    cout_o <= fa_c;
                    ovf_o  <= c_msb ^ fa_c;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed operations against an arithmetic reference model.
module tb_serial_adder;
    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] a_i = '0, b_i = '0;
    logic       cin_i = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub_i = 1'b0;
`endif
    logic       busy_o, done_o, cout_o, ovf_o;
    logic [7:0] s_o;
    int checks = 0, errors = 0;
    logic [7:0] exp_s = '0;
    logic       exp_c = 1'b0, exp_v = 1'b0;

    serial_adder #(.WIDTH(8)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .start_i(start_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .cin_i  (cin_i),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i  (sub_i),
`endif
        .busy_o (busy_o),
        .done_o (done_o),
        .s_o    (s_o),
        .cout_o (cout_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_held();
        check("s_hold", 32'(s_o), 32'(exp_s));
        check("cout_hold", 32'(cout_o), 32'(exp_c));
        check("ovf_hold", 32'(ovf_o), 32'(exp_v));
    endtask

    // Called before a rising edge; returns at the negedge of the DONE cycle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic sub, input logic hold);
        logic [7:0] bb;
        logic [8:0] sum;
        a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i = sub;
`endif
        bb  = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + ((sub | c) ? 9'd1 : 9'd0);
        @(posedge clk_i); #1;
        start_i = hold;
        for (int i = 1; i <= 8; i++) begin
            if (hold) begin
                a_i = 8'($urandom); b_i = 8'($urandom); cin_i = 1'($urandom);
            end
            @(negedge clk_i);
            check("busy", 32'(busy_o), 32'd1);
            check("done_early", 32'(done_o), 32'd0);
            check_held();
        end
        exp_s = sum[7:0];
        exp_c = sum[8];
        exp_v = (a[7] == bb[7]) && (sum[7] != a[7]);
        @(negedge clk_i);
        start_i = 1'b0;
        check("done", 32'(done_o), 32'd1);
        check("busy_done", 32'(busy_o), 32'd0);
        check("s", 32'(s_o), 32'(exp_s));
        check("cout", 32'(cout_o), 32'(exp_c));
        check("ovf", 32'(ovf_o), 32'(exp_v));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            check("idle_done", 32'(done_o), 32'd0);
            check("idle_busy", 32'(busy_o), 32'd0);
            check_held();
        end
    endtask

    initial begin
        logic sub;
        repeat (2) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check_held();
        rstn_i = 1'b1;
        idle_cycles(2);
        do_op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        do_op(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
        idle_cycles(1);
        // start held through SHIFT with changing operands, then back-to-back in DONE
        do_op(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
        do_op(8'hC8, 8'h9C, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        // reset in the middle of an operation
        a_i = 8'hAA; b_i = 8'h55; cin_i = 1'b1; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        exp_s = '0; exp_c = 1'b0; exp_v = 1'b0;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        check_held();
        @(negedge clk_i);
        rstn_i = 1'b1;
        idle_cycles(12);
        do_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        idle_cycles(1);
        do_op(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
`endif
        for (int n = 0; n < 40; n++) begin
            sub = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub = 1'($urandom);
`endif
            do_op(8'($urandom), 8'($urandom), 1'($urandom), sub, 1'($urandom_range(0, 3) == 0));
            idle_cycles(int'($urandom_range(0, 2)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
